// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if: stimulus/config/status bundle of the programmable serial pattern detector.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);
    logic               en;
    logic               x;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;
    logic               cfg_err;
    modport master (
        output en, x, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  z, match_cnt, cnt_sat, cfg_err
    );
    modport slave (
        input  en, x, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output z, match_cnt, cnt_sat, cfg_err
    );
endinterface

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with overlap mode and saturating match counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] RST_PAT = 8'h0D,
    parameter int                 RST_LEN = 4,
    parameter logic               RST_OVL = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    seq_detect_prog_if.slave      sd_if
);
    localparam int LW = $clog2(MAX_LEN + 1);
    logic [MAX_LEN-1:0] hist_q, hist_d, hist_n, pat_q, pat_d, mask;
    logic [LW-1:0]      fill_q, fill_d, fill_n, len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovl_q, ovl_d, z_q, z_d, err_q, err_d, match, len_ok, ld;
    always_comb begin
        hist_n = {hist_q[MAX_LEN-2:0], sd_if.x};
        fill_n = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        mask   = ~({MAX_LEN{1'b1}} << len_q);
        match  = (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);
        len_ok = (sd_if.cfg_len != '0) && (sd_if.cfg_len <= LW'(MAX_LEN));
        ld     = sd_if.cfg_we && len_ok;
        pat_d  = ld ? sd_if.cfg_pattern : pat_q;
        len_d  = ld ? sd_if.cfg_len : len_q;
        ovl_d  = ld ? sd_if.cfg_overlap : ovl_q;
        err_d  = sd_if.cfg_we && !len_ok;
        z_d    = !sd_if.cfg_we && sd_if.en && match;
        hist_d = sd_if.cfg_we ? '0 : sd_if.en ? hist_n : hist_q;
        // Non-overlapping mode restarts progress after a hit so no matched bit is reused
        fill_d = sd_if.cfg_we ? '0 : !sd_if.en ? fill_q : (match && !ovl_q) ? '0 : fill_n;
        cnt_d  = sd_if.cnt_clr ? '0 : (z_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= RST_PAT;
            len_q  <= LW'(RST_LEN);
            ovl_q  <= RST_OVL;
            z_q    <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            z_q    <= z_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end
    assign sd_if.z         = z_q;
    assign sd_if.match_cnt = cnt_q;
    assign sd_if.cnt_sat   = &cnt_q;
    assign sd_if.cfg_err   = err_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed scenarios plus random traffic against a queue-based reference model.
module tb_seq_detect_prog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(8)) b1 ();
    seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) b2 ();
    seq_detect_prog #(.CNT_W(8)) u1 (.clk(clk), .rst(rst), .sd_if(b1));
    seq_detect_prog #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .sd_if(b2));
    assign b2.en          = b1.en;
    assign b2.x           = b1.x;
    assign b2.cfg_we      = b1.cfg_we;
    assign b2.cfg_pattern = b1.cfg_pattern;
    assign b2.cfg_len     = b1.cfg_len;
    assign b2.cfg_overlap = b1.cfg_overlap;
    assign b2.cnt_clr     = b1.cnt_clr;
    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: the bits received since the last clear, newest at the back
    bit q[$];
    logic [7:0] mpat = 8'h0D;
    int mlen = 4;
    bit movl = 1'b1;
    int c8 = 0, c2 = 0;
    bit ez = 0, eerr = 0;
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            mpat = 8'h0D; mlen = 4; movl = 1'b1;
            c8 = 0; c2 = 0; ez = 0; eerr = 0;
        end else begin
            bit m;
            int l;
            m = 0;
            eerr = 0;
            if (b1.cfg_we) begin
                q.delete();
                l = int'(b1.cfg_len);
                if (l >= 1 && l <= 8) begin
                    mpat = b1.cfg_pattern; mlen = l; movl = b1.cfg_overlap;
                end else eerr = 1;
            end else if (b1.en) begin
                q.push_back(b1.x);
                if (q.size() > 8) void'(q.pop_front());
                m = q.size() >= mlen;
                for (int i = 0; i < mlen; i++)
                    if (m && q[q.size()-1-i] != mpat[i]) m = 0;
                if (m && !movl) q.delete();
            end
            ez = m;
            if (b1.cnt_clr) begin
                c8 = 0; c2 = 0;
            end else if (m) begin
                if (c8 < 255) c8++;
                if (c2 < 3) c2++;
            end
            #1;
            chk("z", int'(b1.z), int'(ez));
            chk("z_w2", int'(b2.z), int'(ez));
            chk("cnt", int'(b1.match_cnt), c8);
            chk("cnt_w2", int'(b2.match_cnt), c2);
            chk("sat", int'(b1.cnt_sat), int'(c8 == 255));
            chk("sat_w2", int'(b2.cnt_sat), int'(c2 == 3));
            chk("err", int'(b1.cfg_err), int'(eerr));
            chk("err_w2", int'(b2.cfg_err), int'(eerr));
        end
    end

    task automatic drive(input logic xv, input logic ev, input logic clr = 1'b0);
        @(negedge clk);
        b1.x = xv; b1.en = ev; b1.cfg_we = 1'b0; b1.cnt_clr = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic clr = 1'b0);
        @(negedge clk);
        b1.x = 1'b1; b1.en = 1'b1; b1.cfg_we = 1'b1; b1.cnt_clr = clr;
        b1.cfg_pattern = p; b1.cfg_len = l; b1.cfg_overlap = o;
        @(posedge clk);
        #2;
    endtask

    task automatic run(input logic [6:0] xs, input logic [6:0] ens, input logic [6:0] zs, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(xs[n-1-i], ens[n-1-i]);
            chk({tag, "_z"}, int'(b1.z), int'(zs[n-1-i]));
        end
    endtask

    initial begin
        b1.x = 0; b1.en = 0; b1.cfg_we = 0; b1.cnt_clr = 0;
        b1.cfg_pattern = '0; b1.cfg_len = '0; b1.cfg_overlap = 0;
        #1;
        chk("rst_z", int'(b1.z), 0);
        chk("rst_cnt", int'(b1.match_cnt), 0);
        chk("rst_err", int'(b1.cfg_err), 0);
        chk("rst_sat", int'(b1.cnt_sat), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        run(7'b1101101, 7'b1111111, 7'b0001001, 7, "t1");
        chk("t1_cnt", int'(b1.match_cnt), 2);
        cfg(8'h0D, 4'd4, 1'b0, 1'b1);
        chk("t2_cfg_err", int'(b1.cfg_err), 0);
        chk("t2_cnt_clr", int'(b1.match_cnt), 0);
        run(7'b1101101, 7'b1111111, 7'b0001000, 7, "t2");
        chk("t2_cnt", int'(b1.match_cnt), 1);
        cfg(8'h16, 4'd5, 1'b1);
        run(7'b0101110, 7'b0110111, 7'b0000001, 6, "t3");
        chk("t3_cnt", int'(b1.match_cnt), 2);
        cfg(8'h0D, 4'd4, 1'b1);
        cfg(8'hFF, 4'd0, 1'b0);
        chk("t4_err0", int'(b1.cfg_err), 1);
        drive(1'b0, 1'b0);
        chk("t4_err_pulse", int'(b1.cfg_err), 0);
        cfg(8'hFF, 4'd9, 1'b0);
        chk("t4_err9", int'(b1.cfg_err), 1);
        run(7'b0001101, 7'b0001111, 7'b0000001, 4, "t4");
        chk("t4_cnt", int'(b1.match_cnt), 3);
        drive(1'b0, 1'b0, 1'b1);
        cfg(8'h01, 4'd1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1);
            chk("t5_z", int'(b1.z), 1);
            chk("t5_cnt2", int'(b2.match_cnt), i < 3 ? i : 3);
        end
        chk("t5_sat", int'(b2.cnt_sat), 1);
        chk("t5_cnt8", int'(b1.match_cnt), 5);
        drive(1'b1, 1'b1, 1'b1);
        chk("t5_clr_z", int'(b1.z), 1);
        chk("t5_clr_cnt2", int'(b2.match_cnt), 0);
        chk("t5_clr_cnt8", int'(b1.match_cnt), 0);
        cfg(8'h0D, 4'd4, 1'b1);
        drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_z", int'(b1.z), 0);
        chk("t6_rst_cnt", int'(b1.match_cnt), 0);
        @(posedge clk);
        #2;
        chk("t6_rst_hold", int'(b1.z), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        drive(1'b1, 1'b1);
        chk("t6_z", int'(b1.z), 0);
        chk("t6_cnt", int'(b1.match_cnt), 0);
        run(7'b0000101, 7'b0000111, 7'b0000001, 3, "t6b");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                cfg(8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)),
                    1'($urandom), 1'($urandom_range(0, 3) == 0));
            end else begin
                drive(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
